// File: rtl/mux_n_stream_reg.sv
// N-way registered stream multiplexer with valid/ready handshake and a one-entry output register.
// MODE=0 picks the channel named by S; MODE=1 arbitrates round-robin over valid channels.
module mux_n_stream_reg #(
    parameter  int N    = 4,
    parameter  int W    = 8,
    parameter  int MODE = 0,
    localparam int SW   = $clog2(N)
) (
    input  logic            CK,
    input  logic            RN,
    input  logic [N*W-1:0]  A,
    input  logic [N-1:0]    AV,
    output logic [N-1:0]    AR,
    input  logic [SW-1:0]   S,
    output logic [W-1:0]    Z,
    output logic            ZV,
    input  logic            ZR,
    output logic [SW-1:0]   GNT
);

    logic          load_en;
    logic          s_legal;
    logic          av_at_s;
    logic          sel_ok;
    logic          xfer;
    logic [SW-1:0] sel;
    logic [SW-1:0] ptr;
    logic [SW-1:0] ptr_after_sel;
    logic [W-1:0]  sel_data;

    assign load_en       = ~ZV | ZR;
    assign s_legal       = (32'(S) < 32'(N));
    assign xfer          = load_en & sel_ok;
    assign ptr_after_sel = (sel == SW'(N - 1)) ? '0 : sel + 1'b1;

    always_comb begin
        av_at_s = 1'b0;
        for (int i = 0; i < N; i++)
            if (S == SW'(i)) av_at_s = AV[i];
    end

    // Round-robin search: first the channels at or above ptr, then wrap to those below it.
    always_comb begin
        sel    = '0;
        sel_ok = 1'b0;
        if (MODE == 0) begin
            sel    = S;
            sel_ok = s_legal & av_at_s;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!sel_ok && AV[i] && (SW'(i) >= ptr)) begin
                    sel    = SW'(i);
                    sel_ok = 1'b1;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!sel_ok && AV[i] && (SW'(i) < ptr)) begin
                    sel    = SW'(i);
                    sel_ok = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++)
            if (sel == SW'(i)) sel_data = A[i*W +: W];
    end

    // Ready is forced low during reset so no producer sees a handshake while the register is cleared.
    always_comb begin
        AR = '0;
        for (int i = 0; i < N; i++)
            AR[i] = RN & load_en & (sel == SW'(i)) & ((MODE == 1) ? AV[i] : s_legal);
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            Z   <= '0;
            ZV  <= 1'b0;
            GNT <= '0;
            ptr <= '0;
        end else if (xfer) begin
            Z   <= sel_data;
            ZV  <= 1'b1;
            GNT <= sel;
            if (MODE == 1) ptr <= ptr_after_sel;
        end else if (ZV && ZR) begin
            ZV <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_n_stream_reg.sv
// Bench for mux_n_stream_reg: four instances (N=4 select, N=4 round-robin, N=5 select, N=3 round-robin)
// compared every cycle against a transaction-level reference model, plus directed scenarios.
module tb_mux_n_stream_reg;

    logic        ck = 1'b0;
    logic        rn;

    logic [31:0] a0;  logic [3:0] av0; logic [3:0] ar0; logic [1:0] s0;
    logic [7:0]  z0;  logic zv0; logic zr0; logic [1:0] g0;
    logic [31:0] a1;  logic [3:0] av1; logic [3:0] ar1; logic [1:0] s1;
    logic [7:0]  z1;  logic zv1; logic zr1; logic [1:0] g1;
    logic [39:0] a5;  logic [4:0] av5; logic [4:0] ar5; logic [2:0] s5;
    logic [7:0]  z5;  logic zv5; logic zr5; logic [2:0] g5;
    logic [23:0] a3;  logic [2:0] av3; logic [2:0] ar3; logic [1:0] s3;
    logic [7:0]  z3;  logic zv3; logic zr3; logic [1:0] g3;

    int total = 0;
    int bad   = 0;

    int         m_zv [4];
    int         m_ptr[4];
    int         m_gnt[4];
    logic [7:0] m_z  [4];

    always #5 ck = ~ck;

    mux_n_stream_reg #(.N(4), .W(8), .MODE(0)) dut0 (
        .CK(ck), .RN(rn), .A(a0), .AV(av0), .AR(ar0), .S(s0),
        .Z(z0), .ZV(zv0), .ZR(zr0), .GNT(g0));
    mux_n_stream_reg #(.N(4), .W(8), .MODE(1)) dut1 (
        .CK(ck), .RN(rn), .A(a1), .AV(av1), .AR(ar1), .S(s1),
        .Z(z1), .ZV(zv1), .ZR(zr1), .GNT(g1));
    mux_n_stream_reg #(.N(5), .W(8), .MODE(0)) dut5 (
        .CK(ck), .RN(rn), .A(a5), .AV(av5), .AR(ar5), .S(s5),
        .Z(z5), .ZV(zv5), .ZR(zr5), .GNT(g5));
    mux_n_stream_reg #(.N(3), .W(8), .MODE(1)) dut3 (
        .CK(ck), .RN(rn), .A(a3), .AV(av3), .AR(ar3), .S(s3),
        .Z(z3), .ZV(zv3), .ZR(zr3), .GNT(g3));

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic get_dut(input int id, output int n, output int mode, output logic [39:0] a,
                           output int av, output int s, output int zr, output logic [39:0] ar,
                           output logic [39:0] z, output logic [39:0] zv, output logic [39:0] g);
        case (id)
            0: begin n = 4; mode = 0; a = 40'(a0); av = int'(av0); s = int'(s0); zr = int'(zr0);
                     ar = 40'(ar0); z = 40'(z0); zv = 40'(zv0); g = 40'(g0); end
            1: begin n = 4; mode = 1; a = 40'(a1); av = int'(av1); s = int'(s1); zr = int'(zr1);
                     ar = 40'(ar1); z = 40'(z1); zv = 40'(zv1); g = 40'(g1); end
            2: begin n = 5; mode = 0; a = a5;      av = int'(av5); s = int'(s5); zr = int'(zr5);
                     ar = 40'(ar5); z = 40'(z5); zv = 40'(zv5); g = 40'(g5); end
            default: begin n = 3; mode = 1; a = 40'(a3); av = int'(av3); s = int'(s3); zr = int'(zr3);
                     ar = 40'(ar3); z = 40'(z3); zv = 40'(zv3); g = 40'(g3); end
        endcase
    endtask

    // Reference pick: either the requested index, or the first valid channel at ptr, ptr+1, ... mod n.
    function automatic void pick(input int n, input int mode, input int av, input int s,
                                 input int ptr, output int sel, output bit ok);
        sel = 0;
        ok  = 1'b0;
        if (mode == 0) begin
            sel = s;
            ok  = (s < n) && (((av >> s) & 1) == 1);
        end else begin
            for (int k = 0; k < n; k++) begin
                int c = (ptr + k) % n;
                if (!ok && (((av >> c) & 1) == 1)) begin
                    sel = c;
                    ok  = 1'b1;
                end
            end
        end
    endfunction

    task automatic model_reset();
        for (int id = 0; id < 4; id++) begin
            m_zv[id] = 0; m_ptr[id] = 0; m_gnt[id] = 0; m_z[id] = 8'h00;
        end
    endtask

    task automatic check_output(input string tag);
        int n, mode, av, s, zr;
        logic [39:0] a, ar, z, zv, g;
        for (int id = 0; id < 4; id++) begin
            get_dut(id, n, mode, a, av, s, zr, ar, z, zv, g);
            chk($sformatf("%s_z%0d", tag, id), z, 40'(m_z[id]));
            chk($sformatf("%s_zv%0d", tag, id), zv, 40'(m_zv[id]));
            chk($sformatf("%s_gnt%0d", tag, id), g, 40'(m_gnt[id]));
        end
    endtask

    // One clock: check ready against the model, predict the edge, then check the registered outputs.
    task automatic apply_stimulus(input string tag);
        int n, mode, av, s, zr, sel, exp_ar;
        bit ok, load;
        logic [39:0] a, ar, z, zv, g;
        int nzv[4]; int nptr[4]; int ngnt[4]; logic [7:0] nz[4];
        #1;
        for (int id = 0; id < 4; id++) begin
            get_dut(id, n, mode, a, av, s, zr, ar, z, zv, g);
            pick(n, mode, av, s, m_ptr[id], sel, ok);
            load   = (m_zv[id] == 0) || (zr != 0);
            exp_ar = (rn && load && ((mode == 1) ? ok : (s < n))) ? (1 << sel) : 0;
            chk($sformatf("%s_ar%0d", tag, id), ar, 40'(exp_ar));
            nzv[id] = m_zv[id]; nptr[id] = m_ptr[id]; ngnt[id] = m_gnt[id]; nz[id] = m_z[id];
            if (!rn) begin
                nzv[id] = 0; nptr[id] = 0; ngnt[id] = 0; nz[id] = 8'h00;
            end else if (load && ok) begin
                nz[id]   = a[sel*8 +: 8];
                ngnt[id] = sel;
                nzv[id]  = 1;
                if (mode == 1) nptr[id] = (sel + 1) % n;
            end else if ((m_zv[id] != 0) && (zr != 0)) begin
                nzv[id] = 0;
            end
        end
        @(posedge ck);
        #1;
        for (int id = 0; id < 4; id++) begin
            m_zv[id] = nzv[id]; m_ptr[id] = nptr[id]; m_gnt[id] = ngnt[id]; m_z[id] = nz[id];
        end
        check_output(tag);
    endtask

    task automatic idle_inputs();
        a0 = '0; av0 = '0; s0 = '0; zr0 = 1'b1;
        a1 = '0; av1 = '0; s1 = '0; zr1 = 1'b1;
        a5 = '0; av5 = '0; s5 = '0; zr5 = 1'b1;
        a3 = '0; av3 = '0; s3 = '0; zr3 = 1'b1;
    endtask

    initial begin
        rn = 1'b0;
        idle_inputs();
        model_reset();
        #2;
        check_output("rst");
        chk("rst_ar0", 40'(ar0), 40'h0);
        repeat (2) @(posedge ck);
        #1;
        rn = 1'b1;

        // Select mode: channel 2 with data A5.
        a0 = 32'h00A5_0000; av0 = 4'b0100; s0 = 2'd2; zr0 = 1'b1;
        #1;
        chk("t2_ar", 40'(ar0), 40'h4);
        apply_stimulus("t2");
        chk("t2_z", 40'(z0), 40'hA5);
        chk("t2_zv", 40'(zv0), 40'h1);
        chk("t2_gnt", 40'(g0), 40'h2);

        // Asynchronous reset while a word is held and another is offered.
        zr0 = 1'b0;
        rn  = 1'b0;
        model_reset();
        #1;
        chk("t1_zv", 40'(zv0), 40'h0);
        chk("t1_z", 40'(z0), 40'h0);
        chk("t1_gnt", 40'(g0), 40'h0);
        chk("t1_ar", 40'(ar0), 40'h0);
        apply_stimulus("t1");
        rn = 1'b1;

        // Backpressure: held word survives S/AV changes, then drain and refill in one edge.
        a0 = 32'h005A_0000; av0 = 4'b0100; s0 = 2'd2; zr0 = 1'b1;
        apply_stimulus("t3a");
        a0 = 32'h0000_3C00; av0 = 4'b0010; s0 = 2'd1; zr0 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            apply_stimulus("t3s");
            chk("t3_hold_z", 40'(z0), 40'h5A);
            chk("t3_hold_gnt", 40'(g0), 40'h2);
        end
        zr0 = 1'b1;
        apply_stimulus("t3r");
        chk("t3_z", 40'(z0), 40'h3C);
        chk("t3_gnt", 40'(g0), 40'h1);
        chk("t3_zv", 40'(zv0), 40'h1);
        idle_inputs();

        // N=5 select: index 4 is the last legal one, 5 must be ignored.
        a5 = 40'h77_0000_0000; av5 = 5'b10000; s5 = 3'd4;
        apply_stimulus("t4a");
        chk("t4_gnt4", 40'(g5), 40'h4);
        av5 = 5'b11111; s5 = 3'd5;
        #1;
        chk("t4_ar", 40'(ar5), 40'h0);
        apply_stimulus("t4b");
        chk("t4_zv", 40'(zv5), 40'h0);
        chk("t4_z", 40'(z5), 40'h77);
        idle_inputs();

        // Round-robin N=4 with every channel valid.
        a1 = 32'h4433_2211; av1 = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            apply_stimulus("t5");
            chk($sformatf("t5_gnt_%0d", k), 40'(g1), 40'(k % 4));
            chk($sformatf("t5_zv_%0d", k), 40'(zv1), 40'h1);
        end
        idle_inputs();

        // Round-robin N=3: move the pointer to 1, then alternate between channels 2 and 0.
        a3 = 24'hC3_B2_A1; av3 = 3'b001;
        apply_stimulus("t6a");
        av3 = 3'b101;
        for (int k = 0; k < 3; k++) begin
            apply_stimulus("t6");
            chk($sformatf("t6_gnt_%0d", k), 40'(g3), (k == 1) ? 40'h0 : 40'h2);
        end

        for (int cyc = 0; cyc < 300; cyc++) begin
            a0 = $urandom; av0 = 4'($urandom); s0 = 2'($urandom); zr0 = ($urandom_range(0, 3) != 0);
            a1 = $urandom; av1 = 4'($urandom); s1 = 2'($urandom); zr1 = ($urandom_range(0, 3) != 0);
            a5 = {8'($urandom), 32'($urandom)}; av5 = 5'($urandom); s5 = 3'($urandom);
            zr5 = ($urandom_range(0, 3) != 0);
            a3 = 24'($urandom); av3 = 3'($urandom); s3 = 2'($urandom); zr3 = ($urandom_range(0, 3) != 0);
            apply_stimulus($sformatf("rnd%0d", cyc));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
